// File: rtl/ws2812_pkg.sv
// Shared WS2812 line timing (cycles at 200 MHz) and receiver state encoding.
// The transmitter imports the same CNT_* constants.
package ws2812_pkg;

  localparam int unsigned CNT_GLITCH   = 2 * 10;
  localparam int unsigned CNT_THRESH   = 2 * 53;
  localparam int unsigned CNT_HIGH_MAX = 2 * 100;
  localparam int unsigned CNT_RESET    = 2 * 5000;

  localparam int unsigned PIXEL_W = 24;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {
    S_SYNC,
    S_IDLE,
    S_HIGH,
    S_LOW
  } ws_state_t;

endpackage

// File: rtl/ws2812_in.sv
// WS2812 one-wire receiver: classifies high pulses by width into bits,
// assembles MSB-first 24-bit pixels and detects the low reset gap.
module ws2812_in #(
  parameter int unsigned CNT_GLITCH   = ws2812_pkg::CNT_GLITCH,
  parameter int unsigned CNT_THRESH   = ws2812_pkg::CNT_THRESH,
  parameter int unsigned CNT_HIGH_MAX = ws2812_pkg::CNT_HIGH_MAX,
  parameter int unsigned CNT_RESET    = ws2812_pkg::CNT_RESET
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           ws2812_data_in,
  output logic                           bit_rdy_out,
  output logic                           bit_data_out,
  output logic                           pixel_rdy_out,
  output logic [ws2812_pkg::PIXEL_W-1:0] pixel_data_out,
  output logic                           frame_done_out,
  output logic                           bit_err_out
);
  import ws2812_pkg::*;

  localparam logic [CNT_W-1:0] GLITCH_C = CNT_W'(CNT_GLITCH);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(CNT_THRESH);
  localparam logic [CNT_W-1:0] HMAX_C   = CNT_W'(CNT_HIGH_MAX);
  localparam logic [CNT_W-1:0] RESET_C  = CNT_W'(CNT_RESET);
  localparam logic [4:0]       LAST_IDX = 5'(PIXEL_W - 1);

  logic             sync1, data_s, data_d;
  logic             rise, fall;
  logic [CNT_W-1:0] hi_cnt, lo_cnt;

  ws_state_t        state, state_n;
  logic             bit_ok, bit_val, err_pulse, eof;

  logic [PIXEL_W-2:0] shift;
  logic [4:0]         bit_idx;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1  <= 1'b0;
      data_s <= 1'b0;
      data_d <= 1'b0;
    end else begin
      sync1  <= ws2812_data_in;
      data_s <= sync1;
      data_d <= data_s;
    end
  end

  assign rise = data_s & ~data_d;
  assign fall = ~data_s & data_d;

  // Run-length counters saturate so a stuck line never wraps into a valid width.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hi_cnt <= '0;
      lo_cnt <= '0;
    end else begin
      if (!data_s)           hi_cnt <= '0;
      else if (hi_cnt != '1) hi_cnt <= hi_cnt + 1'b1;
      if (data_s)            lo_cnt <= '0;
      else if (lo_cnt != '1) lo_cnt <= lo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= S_SYNC;
    else           state <= state_n;
  end

  // A gap that ends exactly as the next pulse rises still counts; go straight to S_HIGH.
  always_comb begin
    state_n   = state;
    bit_ok    = 1'b0;
    bit_val   = 1'b0;
    err_pulse = 1'b0;
    eof       = 1'b0;
    case (state)
      S_SYNC: if (lo_cnt == RESET_C) state_n = rise ? S_HIGH : S_IDLE;
      S_IDLE: if (rise) state_n = S_HIGH;
      S_HIGH: begin
        if (fall) begin
          if (hi_cnt < GLITCH_C || hi_cnt > HMAX_C) begin
            err_pulse = 1'b1;
            state_n   = S_SYNC;
          end else begin
            bit_ok  = 1'b1;
            bit_val = (hi_cnt >= THRESH_C);
            state_n = S_LOW;
          end
        end
      end
      S_LOW: begin
        if (lo_cnt == RESET_C) begin
          eof     = 1'b1;
          state_n = rise ? S_HIGH : S_IDLE;
        end else if (rise) begin
          state_n = S_HIGH;
        end
      end
      default: state_n = S_SYNC;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bit_rdy_out    <= 1'b0;
      bit_data_out   <= 1'b0;
      pixel_rdy_out  <= 1'b0;
      pixel_data_out <= '0;
      frame_done_out <= 1'b0;
      bit_err_out    <= 1'b0;
      shift          <= '0;
      bit_idx        <= '0;
    end else begin
      bit_rdy_out    <= bit_ok;
      pixel_rdy_out  <= 1'b0;
      frame_done_out <= eof;
      bit_err_out    <= err_pulse | (eof && bit_idx != '0);
      if (bit_ok) bit_data_out <= bit_val;
      if (err_pulse || eof) begin
        bit_idx <= '0;
      end else if (bit_ok) begin
        if (bit_idx == LAST_IDX) begin
          pixel_data_out <= {shift, bit_val};
          pixel_rdy_out  <= 1'b1;
          bit_idx        <= '0;
        end else begin
          shift   <= {shift[PIXEL_W-3:0], bit_val};
          bit_idx <= bit_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ws2812_in.sv
// Bench for ws2812_in: event-stream comparison against a pulse-level model,
// a width-sweep vector table and directed multi-cycle sequences.
module tb_ws2812_in;

  localparam int GLITCH = 20;
  localparam int THRESH = 106;
  localparam int HMAX   = 200;
  localparam int RST    = 1000;
  localparam int GAP    = RST + 10;

  localparam int EV_BIT = 0;
  localparam int EV_PIX = 1;
  localparam int EV_ERR = 2;
  localparam int EV_FD  = 3;

  typedef struct {
    int          kind;
    logic [23:0] val;
    int          cyc;
  } ev_t;

  typedef struct {
    int   w;
    int   kind;
    logic b;
  } vec_t;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        line = 1'b0;
  logic        bit_rdy_out, bit_data_out, pixel_rdy_out, frame_done_out, bit_err_out;
  logic [23:0] pixel_data_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ev_t act_q[$];
  ev_t exp_q[$];

  // Model state: line-level view of the protocol.
  bit          synced;
  bit          any_bit;
  int          nbits;
  int          lo_run;
  logic [23:0] acc;

  ws2812_in #(
    .CNT_RESET(RST)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .ws2812_data_in(line),
    .bit_rdy_out   (bit_rdy_out),
    .bit_data_out  (bit_data_out),
    .pixel_rdy_out (pixel_rdy_out),
    .pixel_data_out(pixel_data_out),
    .frame_done_out(frame_done_out),
    .bit_err_out   (bit_err_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (bit_rdy_out)    act_q.push_back('{EV_BIT, {23'b0, bit_data_out}, cyc});
      if (pixel_rdy_out)  act_q.push_back('{EV_PIX, pixel_data_out, cyc});
      if (bit_err_out)    act_q.push_back('{EV_ERR, 24'h0, cyc});
      if (frame_done_out) act_q.push_back('{EV_FD, 24'h0, cyc});
    end
  end

  function automatic void m_reset();
    synced  = 1'b0;
    any_bit = 1'b0;
    nbits   = 0;
    lo_run  = 0;
    acc     = '0;
  endfunction

  function automatic void push(input int k, input logic [23:0] v);
    exp_q.push_back('{k, v, 0});
  endfunction

  function automatic void m_pulse(input int w);
    logic b;
    lo_run = 0;
    if (synced) begin
      if (w < GLITCH || w > HMAX) begin
        push(EV_ERR, 24'h0);
        synced  = 1'b0;
        nbits   = 0;
        any_bit = 1'b0;
      end else begin
        b = (w >= THRESH);
        push(EV_BIT, {23'b0, b});
        acc     = {acc[22:0], b};
        nbits   = nbits + 1;
        any_bit = 1'b1;
        if (nbits == 24) begin
          push(EV_PIX, acc);
          nbits = 0;
        end
      end
    end
  endfunction

  function automatic void m_low(input int l);
    int p;
    p      = lo_run;
    lo_run = lo_run + l;
    if (p < RST && lo_run >= RST) begin
      if (synced && any_bit) begin
        if (nbits != 0) push(EV_ERR, 24'h0);
        push(EV_FD, 24'h0);
      end
      synced  = 1'b1;
      nbits   = 0;
      any_bit = 1'b0;
    end
  endfunction

  task automatic pulse(input int w);
    m_pulse(w);
    line = 1'b1;
    repeat (w) @(negedge clk_in);
  endtask

  task automatic low(input int l);
    m_low(l);
    line = 1'b0;
    repeat (l) @(negedge clk_in);
  endtask

  task automatic bit0();
    pulse(70);
    low(180);
  endtask

  task automatic bit1();
    pulse(140);
    low(110);
  endtask

  task automatic send_word(input logic [23:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      if (v[23-i]) bit1();
      else         bit0();
    end
  endtask

  task automatic check_events(input string name);
    int n;
    low(8);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s event count: got %0d, expected %0d", name, act_q.size(), exp_q.size());
    end
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (act_q[i].kind != exp_q[i].kind || act_q[i].val != exp_q[i].val) begin
        errors++;
        $display("FAIL %s event %0d: got kind %0d val %h, expected kind %0d val %h",
                 name, i, act_q[i].kind, act_q[i].val, exp_q[i].kind, exp_q[i].val);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic check_zero(input string name);
    logic [28:0] got;
    got = {bit_rdy_out, bit_data_out, pixel_rdy_out, frame_done_out, bit_err_out, pixel_data_out};
    checks++;
    if (got != '0) begin
      errors++;
      $display("FAIL %s outputs: got %h, expected 0", name, got);
    end
  endtask

  task automatic check_val(input string name, input logic [23:0] got, input logic [23:0] want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  initial begin
    vec_t tbl[6];
    int   lat;
    logic got_bit, got_pix;
    int   ce, cf, w, r;

    tbl[0] = '{19,  EV_ERR, 1'b0};
    tbl[1] = '{20,  EV_BIT, 1'b0};
    tbl[2] = '{105, EV_BIT, 1'b0};
    tbl[3] = '{106, EV_BIT, 1'b1};
    tbl[4] = '{200, EV_BIT, 1'b1};
    tbl[5] = '{201, EV_ERR, 1'b0};

    // Reset state
    m_reset();
    repeat (3) @(negedge clk_in);
    check_zero("reset");
    rst_n_in = 1'b1;

    // First bit latency: 3 edges from the first edge that samples the line low
    low(GAP);
    m_pulse(70);
    line = 1'b1;
    repeat (70) @(negedge clk_in);
    line    = 1'b0;
    lat     = 0;
    got_bit = 1'b1;
    got_pix = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_in);
      if (lat == 0 && bit_rdy_out) begin
        lat     = k;
        got_bit = bit_data_out;
        got_pix = pixel_rdy_out;
      end
    end
    m_low(10);
    check_val("bit latency", 24'(lat), 24'd3);
    check_val("first bit value", {23'b0, got_bit}, 24'h0);
    check_val("first bit no pixel", {23'b0, got_pix}, 24'h0);
    low(170);
    low(GAP);
    check_events("first bit frame");

    // Full pixel and clean frame end
    send_word(24'hA5C33C, 24);
    low(GAP);
    check_events("pixel A5C33C");
    check_val("pixel_data A5C33C", pixel_data_out, 24'hA5C33C);

    // Width sweep from the vector table
    for (int i = 0; i < 6; i++) begin
      act_q.delete();
      exp_q.delete();
      pulse(tbl[i].w);
      low(180);
      checks++;
      if (act_q.size() != 1 || act_q[0].kind != tbl[i].kind ||
          (tbl[i].kind == EV_BIT && act_q[0].val[0] != tbl[i].b)) begin
        errors++;
        $display("FAIL sweep W=%0d: got %0d events (first kind %0d val %h), expected kind %0d bit %0d",
                 tbl[i].w, act_q.size(), (act_q.size() > 0) ? act_q[0].kind : -1,
                 (act_q.size() > 0) ? act_q[0].val : 24'h0, tbl[i].kind, tbl[i].b);
      end
      if (tbl[i].kind == EV_ERR) begin
        act_q.delete();
        bit1();
        low(GAP);
        checks++;
        if (act_q.size() != 0) begin
          errors++;
          $display("FAIL sweep W=%0d resync: got %0d events, expected 0", tbl[i].w, act_q.size());
        end
      end
    end
    act_q.delete();
    exp_q.delete();

    // Gap boundary: RST-1 low keeps the frame, exactly RST ends it
    bit1();
    bit0();
    pulse(140);
    low(RST - 1);
    pulse(70);
    low(RST);
    pulse(140);
    low(180);
    check_events("gap boundary");
    low(GAP);
    check_events("gap boundary end");

    // Line high at reset release, 48 bits with no gap are ignored
    rst_n_in = 1'b0;
    line     = 1'b1;
    m_reset();
    act_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    pulse(300);
    low(100);
    send_word(24'h123456, 24);
    send_word(24'h789ABC, 24);
    check_events("unsynced 48 bits");
    low(GAP);
    send_word(24'hFEDCBA, 24);
    low(GAP);
    check_events("after resync");

    // Partial pixel at frame end
    send_word(24'hF0F000, 12);
    low(GAP);
    ce = -1;
    cf = -2;
    for (int i = 0; i < act_q.size(); i++) begin
      if (act_q[i].kind == EV_ERR) ce = act_q[i].cyc;
      if (act_q[i].kind == EV_FD)  cf = act_q[i].cyc;
    end
    checks++;
    if (ce != cf) begin
      errors++;
      $display("FAIL partial same-cycle: err at %0d, frame_done at %0d, expected equal", ce, cf);
    end
    check_events("partial pixel");
    send_word(24'h5A5A5A, 24);
    low(GAP);
    check_events("pixel after partial");

    // Reset mid-pixel
    send_word(24'hC3C3C3, 10);
    low(50);
    check_val("pixel hold", pixel_data_out, 24'h5A5A5A);
    rst_n_in = 1'b0;
    #1;
    check_zero("async reset");
    m_reset();
    act_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    low(20);
    send_word(24'h0F0F0F, 24);
    check_events("post-reset unsynced");
    low(GAP);
    send_word(24'h0FF00F, 24);
    low(GAP);
    check_events("post-reset pixel");

    // Randomized pulse stream
    for (int i = 0; i < 50; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4) w = ($urandom_range(0, 1) == 0) ? $urandom_range(1, GLITCH - 1)
                                                 : $urandom_range(HMAX + 1, 300);
      else       w = $urandom_range(GLITCH, HMAX);
      pulse(w);
      r = $urandom_range(0, 99);
      if (r < 8) low($urandom_range(RST, RST + 100));
      else       low($urandom_range(20, 300));
      if (i % 10 == 9) check_events("random");
    end
    low(GAP);
    check_events("random end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
